// File: rtl/debug_uart_bridge_pkg.sv
// Shared constants for the debug UART bridge: command byte layout, frame length
// and the command FSM state encoding.
package debug_uart_bridge_pkg;

    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_ADDR_MSB = 2;
    localparam int CMD_ADDR_LSB = 0;
    localparam int CMD_RSV_MSB  = 6;
    localparam int CMD_RSV_LSB  = 3;

    // Index of the stop bit in a start + 8 data + stop frame
    localparam logic [3:0] FRAME_LAST = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_STROBE_WR,
        ST_STROBE_RD,
        ST_CAPTURE,
        ST_TX
    } bridge_state_t;

    function automatic logic cmd_is_valid(input logic [7:0] cmd);
        return (cmd[CMD_RSV_MSB:CMD_RSV_LSB] == 4'd0);
    endfunction

endpackage

// File: rtl/debug_uart_rx.sv
// UART receiver: two-flop synchroniser, mid-bit sampling with start re-check and
// stop validation; emits one-cycle rx_valid or rx_ferr per completed frame.
module debug_uart_rx
    import debug_uart_bridge_pkg::*;
#(
    parameter int CLK_DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] DIV_HALF = 16'(CLK_DIV / 2);

    logic        rxd_meta;
    logic        rxd_sync;
    logic        rxd_prev;
    logic        active;
    logic [15:0] bit_cnt;
    logic [3:0]  bit_idx;
    logic [7:0]  shift;

    assign rx_data = shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // Bit timing restarts on each start edge; every bit, including start and
    // stop, is sampled half a bit period into its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            bit_cnt  <= 16'd0;
            bit_idx  <= 4'd0;
            shift    <= 8'd0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (!active) begin
                if (rxd_prev && !rxd_sync) begin
                    active  <= 1'b1;
                    bit_cnt <= 16'd0;
                    bit_idx <= 4'd0;
                end
            end else begin
                if (bit_cnt == DIV_LAST) begin
                    bit_cnt <= 16'd0;
                    bit_idx <= bit_idx + 4'd1;
                end else begin
                    bit_cnt <= bit_cnt + 16'd1;
                end
                if (bit_cnt == DIV_HALF) begin
                    if (bit_idx == 4'd0) begin
                        if (rxd_sync) begin
                            active <= 1'b0;
                        end
                    end else if (bit_idx < FRAME_LAST) begin
                        shift <= {rxd_sync, shift[7:1]};
                    end else begin
                        active   <= 1'b0;
                        rx_valid <= rxd_sync;
                        rx_ferr  <= !rxd_sync;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/debug_uart_bridge.sv
// Host-side debug bridge: decodes UART command bytes into single-cycle debug
// read/write strobes and returns read data on the UART transmit line.
module debug_uart_bridge
    import debug_uart_bridge_pkg::*;
#(
    parameter int CLK_DIV = 104
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic       TXD,
    output logic [2:0] DEBUG_ADDR,
    output logic [7:0] DEBUG_DIN,
    input  logic [7:0] DEBUG_DOUT,
    output logic       DEBUG_RD,
    output logic       DEBUG_WR,
    output logic       BUSY,
    output logic       OVERRUN
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ferr;
    bridge_state_t state;
    logic [15:0]   tx_cnt;
    logic [3:0]    tx_idx;
    logic [7:0]    tx_shift;

    debug_uart_rx #(
        .CLK_DIV(CLK_DIV)
    ) u_rx (
        .clk     (CLK),
        .rst     (RESET),
        .rxd     (RXD),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    // Command FSM and TX shifter share one block so TXD, strobes and BUSY are
    // all registered and reset asynchronously together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            BUSY       <= 1'b0;
            DEBUG_RD   <= 1'b0;
            DEBUG_WR   <= 1'b0;
            DEBUG_ADDR <= 3'd0;
            DEBUG_DIN  <= 8'd0;
            OVERRUN    <= 1'b0;
            TXD        <= 1'b1;
            tx_cnt     <= 16'd0;
            tx_idx     <= 4'd0;
            tx_shift   <= 8'd0;
        end else begin
            DEBUG_RD <= 1'b0;
            DEBUG_WR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid && cmd_is_valid(rx_data)) begin
                        DEBUG_ADDR <= rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB];
                        BUSY       <= 1'b1;
                        if (rx_data[CMD_WR_BIT]) begin
                            state <= ST_WAIT_DATA;
                        end else begin
                            state    <= ST_STROBE_RD;
                            DEBUG_RD <= 1'b1;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (rx_valid) begin
                        DEBUG_DIN <= rx_data;
                        DEBUG_WR  <= 1'b1;
                        state     <= ST_STROBE_WR;
                    end else if (rx_ferr) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                ST_STROBE_WR: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
                ST_STROBE_RD: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    tx_shift <= DEBUG_DOUT;
                    TXD      <= 1'b0;
                    tx_cnt   <= 16'd0;
                    tx_idx   <= 4'd0;
                    state    <= ST_TX;
                end
                ST_TX: begin
                    // Ones shift in behind the data, so the ninth bit out is the stop bit
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt <= 16'd0;
                        if (tx_idx == FRAME_LAST) begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            tx_idx   <= tx_idx + 4'd1;
                            TXD      <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
            if (rx_valid && (state inside {ST_STROBE_WR, ST_STROBE_RD, ST_CAPTURE, ST_TX})) begin
                OVERRUN <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debug_uart_bridge.sv
// Bench for debug_uart_bridge: directed UART command frames checked against a
// byte-level command model plus literal frame and register expectations.
module tb_debug_uart_bridge;

    localparam int CLK_DIV   = 8;
    localparam int RX_LAT    = 79;
    localparam int READ_HOLD = 3 + 10 * CLK_DIV;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       rxd  = 1'b1;
    logic       txd;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_din;
    logic [7:0] dbg_dout = 8'd0;
    logic       dbg_rd;
    logic       dbg_wr;
    logic       busy;
    logic       overrun;

    debug_uart_bridge #(
        .CLK_DIV(CLK_DIV)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .RXD       (rxd),
        .TXD       (txd),
        .DEBUG_ADDR(dbg_addr),
        .DEBUG_DIN (dbg_din),
        .DEBUG_DOUT(dbg_dout),
        .DEBUG_RD  (dbg_rd),
        .DEBUG_WR  (dbg_wr),
        .BUSY      (busy),
        .OVERRUN   (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_wr;
        logic [2:0] addr;
        logic [7:0] din;
        logic [7:0] reply;
    } strobe_t;

    strobe_t    exp_q[$];
    bit         m_pending_wr;
    logic [2:0] m_addr;
    logic [7:0] m_din;
    bit         m_overrun;
    int         m_hold_until;

    bit         expect_idle = 1'b0;
    int         rd_seen = 0;
    int         wr_seen = 0;
    logic [9:0] cap_frame = 10'd0;

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pending_wr = 1'b0;
        m_addr       = 3'd0;
        m_din        = 8'd0;
        m_overrun    = 1'b0;
        m_hold_until = 0;
    endtask

    // Byte-level view of the bridge: a byte landing while a strobe or reply is
    // still in flight is dropped; otherwise it advances the command protocol.
    task automatic model_rx(input logic [7:0] b, input bit ok, input int done_cyc);
        if (done_cyc < m_hold_until) begin
            if (ok) m_overrun = 1'b1;
        end else if (!ok) begin
            m_pending_wr = 1'b0;
        end else if (m_pending_wr) begin
            m_din = b;
            exp_q.push_back('{1'b1, m_addr, b, 8'd0});
            m_pending_wr = 1'b0;
            m_hold_until = done_cyc + 2;
        end else if (b[6:3] == 4'd0) begin
            m_addr = b[2:0];
            if (b[7]) begin
                m_pending_wr = 1'b1;
            end else begin
                exp_q.push_back('{1'b0, m_addr, m_din, dbg_dout});
                m_hold_until = done_cyc + READ_HOLD;
            end
        end
    endtask

    // Called at a falling clock edge; returns at the end of the stop bit.
    task automatic send_frame(input logic [7:0] b, input bit ok);
        logic [7:0] sh;
        sh = b;
        model_rx(b, ok, cyc + RX_LAT);
        rxd = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = sh[0];
            sh  = sh >> 1;
            repeat (CLK_DIV) @(negedge clk);
        end
        rxd = ok;
        repeat (CLK_DIV) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    strobe_t    cmp_e;
    bit         tx_active = 1'b0;
    int         tx_start  = 0;
    logic [9:0] tx_frame  = 10'd0;
    logic [3:0] bit_k;

    always @(negedge clk) begin
        if (rst) begin
            tx_active = 1'b0;
        end else begin
            if (dbg_rd || dbg_wr) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_strobe", int'({dbg_wr, dbg_rd}), 0);
                end else begin
                    cmp_e = exp_q.pop_front();
                    check_output("strobe_kind", int'({dbg_wr, dbg_rd}), cmp_e.is_wr ? 2 : 1);
                    check_output("strobe_addr", int'(dbg_addr), int'(cmp_e.addr));
                    check_output("strobe_din", int'(dbg_din), int'(cmp_e.din));
                    if (!cmp_e.is_wr) begin
                        tx_active = 1'b1;
                        tx_start  = cyc + 2;
                        tx_frame  = {1'b1, cmp_e.reply, 1'b0};
                    end
                end
                if (dbg_rd) rd_seen++;
                if (dbg_wr) wr_seen++;
            end
            if (tx_active && cyc >= tx_start && cyc < tx_start + 10 * CLK_DIV) begin
                bit_k = 4'((cyc - tx_start) / CLK_DIV);
                check_output("txd_frame_bit", int'(txd), int'(tx_frame[bit_k]));
                if ((cyc - tx_start) % CLK_DIV == CLK_DIV / 2) cap_frame[bit_k] = txd;
                if (cyc == tx_start + 10 * CLK_DIV - 1) check_output("busy_last_stop_cycle", int'(busy), 1);
            end else begin
                if (tx_active && cyc >= tx_start + 10 * CLK_DIV) begin
                    check_output("busy_after_frame", int'(busy), 0);
                    tx_active = 1'b0;
                end
                check_output("txd_idle", int'(txd), 1);
            end
            if (expect_idle) check_output("busy_on_bad_cmd", int'(busy), 0);
        end
    end

    int rd_before;
    int wr_before;

    initial begin
        $display("[TB] debug_uart_bridge bench, CLK_DIV=%0d", CLK_DIV);
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_output("reset_txd", int'(txd), 1);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_strobes", int'({dbg_rd, dbg_wr}), 0);
        check_output("reset_addr", int'(dbg_addr), 0);
        check_output("reset_din", int'(dbg_din), 0);
        check_output("reset_overrun", int'(overrun), 0);
        idle(3);
        rst = 1'b0;
        idle(20);

        $display("[TB] write 0x83,0x5A");
        send_frame(8'h83, 1'b1);
        send_frame(8'h5A, 1'b1);
        idle(40);
        check_output("wr_count", wr_seen, 1);
        check_output("rd_count", rd_seen, 0);
        check_output("wr_addr_hold", int'(dbg_addr), 3);
        check_output("wr_din_hold", int'(dbg_din), 'h5A);
        check_output("wr_busy_done", int'(busy), 0);
        check_output("wr_pending", int'(exp_q.size()), 0);

        $display("[TB] read 0x02 -> 0xC3");
        dbg_dout  = 8'hC3;
        cap_frame = 10'd0;
        rd_before = rd_seen;
        send_frame(8'h02, 1'b1);
        idle(100);
        check_output("rd_count", rd_seen - rd_before, 1);
        check_output("rd_frame_c3", int'(cap_frame), 'h386);
        check_output("rd_addr_hold", int'(dbg_addr), 2);
        check_output("rd_pending", int'(exp_q.size()), 0);

        $display("[TB] reserved bits 0x48 then read 0x01 -> 0x3C");
        expect_idle = 1'b1;
        wr_before   = wr_seen;
        rd_before   = rd_seen;
        send_frame(8'h48, 1'b1);
        idle(20);
        expect_idle = 1'b0;
        check_output("bad_cmd_no_strobe", (rd_seen - rd_before) + (wr_seen - wr_before), 0);
        dbg_dout  = 8'h3C;
        cap_frame = 10'd0;
        send_frame(8'h01, 1'b1);
        idle(100);
        check_output("rd_count", rd_seen - rd_before, 1);
        check_output("rd_frame_3c", int'(cap_frame), 'h278);
        check_output("rd_addr_hold", int'(dbg_addr), 1);

        $display("[TB] framing error on write data, then clean write");
        wr_before = wr_seen;
        send_frame(8'h81, 1'b1);
        send_frame(8'h77, 1'b0);
        idle(16);
        check_output("ferr_no_wr", wr_seen - wr_before, 0);
        check_output("ferr_busy", int'(busy), 0);
        send_frame(8'h81, 1'b1);
        send_frame(8'h11, 1'b1);
        idle(40);
        check_output("wr_count", wr_seen - wr_before, 1);
        check_output("wr_addr_hold", int'(dbg_addr), 1);
        check_output("wr_din_hold", int'(dbg_din), 'h11);
        check_output("overrun_still_clear", int'(overrun), 0);

        $display("[TB] read 0x00 with 0x05 arriving during reply");
        dbg_dout  = 8'hA5;
        cap_frame = 10'd0;
        rd_before = rd_seen;
        send_frame(8'h00, 1'b1);
        send_frame(8'h05, 1'b1);
        idle(100);
        check_output("rd_count", rd_seen - rd_before, 1);
        check_output("rd_frame_a5", int'(cap_frame), 'h34A);
        check_output("overrun_model", int'(overrun), int'(m_overrun));
        check_output("overrun_set", int'(overrun), 1);
        check_output("dropped_addr", int'(dbg_addr), 0);
        check_output("overrun_busy", int'(busy), 0);
        check_output("overrun_pending", int'(exp_q.size()), 0);

        $display("[TB] reset during reply frame");
        dbg_dout  = 8'h96;
        rd_before = rd_seen;
        wr_before = wr_seen;
        send_frame(8'h07, 1'b1);
        for (int i = 0; i < 60 && rd_seen == rd_before; i++) @(negedge clk);
        check_output("rd_before_reset", rd_seen - rd_before, 1);
        idle(30);
        #2 rst = 1'b1;
        #1;
        check_output("async_txd", int'(txd), 1);
        check_output("async_busy", int'(busy), 0);
        check_output("async_strobes", int'({dbg_rd, dbg_wr}), 0);
        check_output("async_addr", int'(dbg_addr), 0);
        check_output("async_din", int'(dbg_din), 0);
        check_output("async_overrun", int'(overrun), 0);
        model_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        idle(100);
        check_output("post_reset_rd", rd_seen - rd_before, 1);
        check_output("post_reset_wr", wr_seen - wr_before, 0);
        check_output("post_reset_busy", int'(busy), 0);
        check_output("post_reset_txd", int'(txd), 1);
        check_output("post_reset_pending", int'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_uart_bridge.md
# debug_uart_bridge

Host-side front end for the CPU core's 8-bit debugger interface. Receives a byte-serial command stream on a UART line, converts each command into a single-cycle `DEBUG_RD` or `DEBUG_WR` strobe with `DEBUG_ADDR` and `DEBUG_DIN` held stable, and returns read data on a UART transmit line. Sits directly upstream of the core's `debugPort`, between the board pins and the core.

## Interface
- `CLK_DIV`, 104: CLK cycles per UART bit; legal range 4..65535.
- `CLK`  in  1  system clock, all logic on its rising edge
- `RESET`  in  1  reset; one clock, asynchronous and active-high
- `RXD`  in  1  UART receive line, asynchronous, idle high
- `TXD`  out  1  UART transmit line, idle high
- `DEBUG_ADDR`  out  3  debug register address to core
- `DEBUG_DIN`  out  8  write data to core
- `DEBUG_DOUT`  in  8  read data from core
- `DEBUG_RD`  out  1  one-cycle read strobe
- `DEBUG_WR`  out  1  one-cycle write strobe
- `BUSY`  out  1  command in progress (states other than IDLE)
- `OVERRUN`  out  1  sticky; a byte was received while the bridge could not accept it

## Operation
- Command byte: bit7 = 1 write / 0 read; bits[2:0] = address; bits[6:3] must be 0000, else the byte is discarded silently and FSM stays IDLE.
- Write = command byte + data byte; read = command byte, bridge replies with one byte.
- RX: `RXD` through 2-flop synchroniser; falling edge in idle starts a frame; start bit re-checked at CLK_DIV/2; if high, false start, return to idle. Data sampled mid-bit, LSB first; stop bit sampled mid-bit; stop = 0 is a framing error, byte discarded, FSM returns to IDLE (pending write command abandoned). Valid byte yields a one-cycle internal `rx_valid`.
- FSM states: IDLE, WAIT_DATA, STROBE_WR, STROBE_RD, CAPTURE, TX.
  - IDLE + valid write cmd -> latch ADDR, WAIT_DATA. IDLE + valid read cmd -> latch ADDR, STROBE_RD.
  - WAIT_DATA + byte -> latch DIN, STROBE_WR. WAIT_DATA + framing error -> IDLE.
  - STROBE_WR: `DEBUG_WR`=1 one cycle -> IDLE.
  - STROBE_RD: `DEBUG_RD`=1 one cycle -> CAPTURE.
  - CAPTURE: load `DEBUG_DOUT` into TX shift register -> TX.
  - TX: send start, 8 data LSB first, stop; -> IDLE after stop bit's last cycle.
- Bytes completing in STROBE_*, CAPTURE or TX are dropped and set `OVERRUN`; cleared only by `RESET`.
- `DEBUG_ADDR`/`DEBUG_DIN` hold last latched values between commands.

## Timing
- Reset values: TXD=1, DEBUG_RD=0, DEBUG_WR=0, DEBUG_ADDR=0, DEBUG_DIN=0, BUSY=0, OVERRUN=0; RX and TX counters cleared, FSM IDLE.
- `rx_valid` in cycle R -> strobe asserted in cycle R+1, exactly one cycle.
- Read: `DEBUG_DOUT` sampled at end of R+2 (one cycle after RD strobe); TXD start bit begins R+3.
- Each TX bit lasts exactly CLK_DIV cycles; frame = 10*CLK_DIV cycles; BUSY falls the cycle after.
- RX latency: start edge to `rx_valid` ≈ 9.5*CLK_DIV + 3 cycles (sync + mid-stop).
- Bit counter 16-bit, counts 0..CLK_DIV-1 and wraps; bit index 0..9.
- `RESET` mid-frame: TXD high in same cycle (async), partial RX/TX discarded, no strobe emitted.
- RX runs continuously, independent of FSM state; RX and TX may overlap.

## Structure
- Shared package/constants include: FSM state encodings, command bit positions (CMD_WR_BIT=7, CMD_ADDR=[2:0], CMD_RSV=[6:3]).
- One sub-module: `debug_uart_rx` (synchroniser, start/stop validation, outputs byte, `rx_valid`, `rx_ferr`). TX shifter and command FSM live in the top.

## Test plan
- CLK_DIV=8; send 0x83, 0x5A -> one DEBUG_WR pulse, ADDR=3, DIN=0x5A, no TXD activity.
- Send 0x02 with DEBUG_DOUT=0xC3 -> one DEBUG_RD pulse ADDR=2; TXD frame 0,1,1,0,0,0,0,1,1,1, each bit 8 cycles, starts 2 cycles after RD.
- Send 0x48 -> no strobes, BUSY stays 0; following 0x01 read works normally.
- Send 0x81 then data byte with stop bit = 0 -> no WR; next 0x81, 0x11 -> WR ADDR=1 DIN=0x11.
- Send 0x00 then immediately 0x05 during TX reply -> 0x05 dropped, OVERRUN=1, only one RD pulse.
- Assert RESET mid TX frame -> TXD=1 at once, all outputs at reset values, no strobe.
